// File: rtl/final_soc_key_in.sv
// Purpose : Avalon-MM input PIO: sync + debounce board inputs, edge capture, level irq.
// Latency : in_port -> data reg 2 + DEBOUNCE_COUNT cycles (2 + 1 if bypassed); readdata 1 cycle after address.
// Backpressure: none; the slave always accepts, reads are fixed one-cycle latency.
//
// Ports:
//   clk, reset_n            : single clock, async active-low reset
//   address/chipselect/
//   write_n/writedata       : Avalon-MM slave write/read-address side
//   in_port [WIDTH]         : asynchronous external inputs (buttons/switches)
//   readdata [32]           : registered read data
//   irq                     : |(edge_capture & irq_mask), from registers only
module final_soc_key_in #(
  parameter int WIDTH          = 4,
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int EDGE_TYPE      = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync_1;
  logic [WIDTH-1:0] sync_2;
  logic [WIDTH-1:0] debounced;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] detect;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_sel;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_wdata = ^writedata;

  // Two-flop synchronizer against metastability on the raw pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= in_port;
      sync_2 <= sync_1;
    end
  end

  generate
    if (DEBOUNCE_COUNT == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) debounced <= '0;
        else          debounced <= sync_2;
      end
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);
      logic [CW-1:0] cnt [WIDTH];

      // A change is accepted only after DEBOUNCE_COUNT consecutive cycles of
      // disagreement; any agreement in between restarts the count.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          debounced <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync_2[i] != debounced[i]) begin
              if (cnt[i] == CNT_LAST) begin
                debounced[i] <= sync_2[i];
                cnt[i]       <= '0;
              end else begin
                cnt[i] <= cnt[i] + CW'(1);
              end
            end else begin
              cnt[i] <= '0;
            end
          end
        end
      end
    end
  endgenerate

  assign rise   = debounced & ~prev;
  assign fall   = ~debounced & prev;
  assign detect = (EDGE_TYPE == 0) ? rise :
                  (EDGE_TYPE == 1) ? fall : (rise | fall);

  assign wr_sel     = chipselect && !write_n;
  assign clear_bits = (wr_sel && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      prev <= debounced;
      if (wr_sel && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      // OR-ing detect in after the clear makes a coincident edge win.
      edge_capture <= (edge_capture & ~clear_bits) | detect;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = debounced;
      2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
      2'd3:    rd_mux[WIDTH-1:0] = edge_capture;
      default: rd_mux = '0;
    endcase
  end

  // Updated every cycle regardless of chipselect; shows pre-write contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_final_soc_key_in.sv
// Purpose : self-checking bench for final_soc_key_in (WIDTH=4, DEBOUNCE_COUNT=4, rising edge).
// Latency : reads checked one cycle after the address is presented.
// Backpressure: none on this slave.
module tb_final_soc_key_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    string       name;
    logic        wr;
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[5];

  final_soc_key_in #(
    .WIDTH(4),
    .DEBOUNCE_COUNT(4),
    .EDGE_TYPE(0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Push the expectation when the read is issued, pop it when readdata lands.
  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    sb_t s;
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    sb_q.push_back('{nm, e});
    @(negedge clk);
    chipselect = 1'b0;
    s = sb_q.pop_front();
    check(s.name, readdata, s.exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;

    vecs[0] = '{"wr_addr0_ignored", 1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h0000_0007};
    vecs[1] = '{"wr_addr1_reads0",  1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0000_0000};
    vecs[2] = '{"wr_cs0_ignored",   1'b1, 1'b0, 2'd2, 32'h0000_000F, 2'd2, 32'h0000_0004};
    vecs[3] = '{"mask_upper_drop",  1'b1, 1'b1, 2'd2, 32'hFFFF_FFF4, 2'd2, 32'h0000_0004};
    vecs[4] = '{"capture_held",     1'b0, 1'b1, 2'd3, 32'h0000_0000, 2'd3, 32'h0000_0004};

    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'hF;

    // Reset with inputs active.
    idle(5);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    idle(10);
    rd(2'd0, 32'h0000_000F, "post_reset_data");
    rd(2'd3, 32'h0000_000F, "post_reset_capture");
    check("post_reset_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h0000_000F, 1'b1);
    rd(2'd3, 32'h0, "w1c_all");
    in_port = 4'h0;
    idle(10);
    rd(2'd0, 32'h0, "inputs_low");
    rd(2'd3, 32'h0, "falling_not_captured");

    // Glitch of 3 cycles is filtered.
    @(negedge clk);
    in_port[1] = 1'b1;
    idle(3);
    in_port[1] = 1'b0;
    idle(10);
    rd(2'd0, 32'h0, "glitch_data");
    rd(2'd3, 32'h0, "glitch_capture");
    in_port[1] = 1'b1;
    idle(10);
    rd(2'd0, 32'h0000_0002, "stable_data");
    rd(2'd3, 32'h0000_0002, "stable_capture");

    // Interrupt path with exact latency.
    wr(2'd3, 32'h2, 1'b1);
    in_port[1] = 1'b0;
    idle(10);
    wr(2'd2, 32'h2, 1'b1);
    check("irq_before_edge", {31'b0, irq}, 32'h0);
    @(negedge clk);
    in_port[1] = 1'b1;
    n = 0;
    while (!irq && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("irq_rise_latency", n, 7);
    wr(2'd3, 32'h2, 1'b1);
    check("irq_clear", {31'b0, irq}, 32'h0);
    rd(2'd3, 32'h0, "capture_cleared");

    // Masking: captured edge only raises irq once unmasked.
    wr(2'd2, 32'h0, 1'b1);
    @(negedge clk);
    in_port[0] = 1'b1;
    idle(10);
    check("irq_masked", {31'b0, irq}, 32'h0);
    rd(2'd3, 32'h1, "masked_capture");
    wr(2'd2, 32'h1, 1'b1);
    check("irq_on_unmask", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1, 1'b1);
    check("irq_off_bit0", {31'b0, irq}, 32'h0);

    // Set/clear collision on bit2: W1C lands on the capture edge.
    wr(2'd2, 32'h4, 1'b1);
    @(negedge clk);
    in_port[2] = 1'b1;
    idle(6);
    check("irq_pre_collision", {31'b0, irq}, 32'h0);
    address    = 2'd3;
    writedata  = 32'h4;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    write_n    = 1'b1;
    chipselect = 1'b0;
    check("irq_collision", {31'b0, irq}, 32'h1);
    rd(2'd3, 32'h4, "collision_capture");

    // Bus isolation table.
    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata, vecs[i].cs);
      rd(vecs[i].raddr, vecs[i].exp, vecs[i].name);
    end

    // Read latency: readdata follows the address exactly one edge later.
    @(negedge clk);
    address = 2'd0;
    #1;
    check("latency_hold", readdata, 32'h4);
    @(negedge clk);
    check("latency_new", readdata, 32'h7);
    check("irq_final", {31'b0, irq}, 32'h1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
